// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - word-granular memory-to-memory copy engine with sticky done flag
// Optional constant-fill mode is compiled in with DMA_FILL_EN.
module dma_copy #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_next;

    logic [31:0]          src_q, dst_q, cur_src, cur_dst, data_q, rd_mux;
    logic [LEN_WIDTH-1:0] len_q, remaining;
    logic                 sel_d, gap, fill_bit, fill_q, fill_start;
    logic                 cfg_hit, cfg_wr, busy, ctrl_wr, start, clear, accept, last;
    logic                 unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // One acknowledge per sel assertion: only the first cycle sel is seen high counts.
    assign cfg_hit   = sel && !sel_d;
    assign cfg_wr    = cfg_hit && (wstrb != 4'h0);
    assign busy      = (state != IDLE);
    assign ctrl_wr   = cfg_wr && (addr[3:2] == 2'd3) && wstrb[0];
    assign start     = ctrl_wr && wdata[0] && !busy;
    assign clear     = ctrl_wr && wdata[1];
    assign accept    = m_valid && m_ready;
    assign last      = (state == WR) && accept && (remaining == LEN_WIDTH'(1));
    assign unused_ok = &{1'b0, addr[1:0]};

`ifdef DMA_FILL_EN
    assign fill_start = wdata[2];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_bit <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            if (ctrl_wr) fill_bit <= wdata[2];
            if (start)   fill_q   <= wdata[2];
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_bit   = 1'b0;
    assign fill_q     = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            2'd0: rd_mux = {src_q[31:2], 2'b00};
            2'd1: rd_mux = dst_q;
            2'd2: rd_mux = 32'(len_q);
            default: rd_mux = {29'd0, fill_bit, done, busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && len_q != '0) state_next = fill_start ? WR : RD;
            RD:   if (accept) state_next = WR;
            WR:   if (accept) state_next = (remaining == LEN_WIDTH'(1)) ? IDLE : (fill_q ? WR : RD);
            default: state_next = IDLE;
        endcase
    end

    // gap forces the one idle cycle after every accepted transfer.
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = 4'h0;
        case (state)
            RD: begin
                m_valid = !gap;
                m_addr  = cur_src;
            end
            WR: begin
                m_valid = !gap;
                m_addr  = cur_dst;
                m_wdata = data_q;
                m_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            data_q    <= '0;
            remaining <= '0;
            sel_d     <= 1'b0;
            gap       <= 1'b0;
            ready     <= 1'b0;
            rdata     <= '0;
            done      <= 1'b0;
        end else begin
            sel_d <= sel;
            ready <= cfg_hit;
            rdata <= cfg_hit ? rd_mux : '0;
            gap   <= accept;
            if (cfg_wr && !busy) begin
                case (addr[3:2])
                    2'd0: src_q <= merge(src_q, wdata, wstrb);
                    2'd1: dst_q <= merge(dst_q, wdata, wstrb) & 32'hFFFF_FFFC;
                    2'd2: len_q <= LEN_WIDTH'(merge(32'(len_q), wdata, wstrb));
                    default: ;
                endcase
            end
            // SRC keeps its low bits so fill data is the full programmed word.
            if (start) begin
                done      <= (len_q == '0);
                cur_src   <= {src_q[31:2], 2'b00};
                cur_dst   <= dst_q;
                remaining <= len_q;
                data_q    <= src_q;
            end else if (last) begin
                done <= 1'b1;
            end else if (clear) begin
                done <= 1'b0;
            end
            if (state == RD && accept) begin
                data_q  <= m_rdata;
                cur_src <= cur_src + 32'd4;
            end
            if (state == WR && accept) begin
                cur_dst   <= cur_dst + 32'd4;
                remaining <= remaining - LEN_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - randomized self-checking bench for dma_copy against a word-copy reference model
module tb_dma_copy;
    logic        clk, reset_n, sel, ready, m_valid, m_ready, done;
    logic [3:0]  addr, wstrb, m_wstrb;
    logic [31:0] wdata, rdata, m_addr, m_wdata, m_rdata;

    dma_copy #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .rdata(rdata), .ready(ready), .m_valid(m_valid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_ready(m_ready), .done(done)
    );

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } txn_t;
    txn_t obs_q[$], exp_q[$];
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int vectors = 0, miscompares = 0, valid_cnt = 0, wait_cnt = 0, last_lat = 0;
    bit hold_wr = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (m_valid) valid_cnt++;

    // Memory responder: random 0-3 wait cycles, one-cycle m_ready per transfer.
    initial begin
        m_ready = 0;
        m_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (m_ready) m_ready = 0;
            else if (m_valid && !(hold_wr && m_wstrb != 4'h0)) begin
                if (wait_cnt == 0) begin
                    m_ready = 1;
                    if (m_wstrb == 4'h0) begin
                        m_rdata = mem[m_addr[11:2]];
                        obs_q.push_back('{1'b0, m_addr, m_rdata});
                    end else begin
                        mem[m_addr[11:2]] = m_wdata;
                        obs_q.push_back('{1'b1, m_addr, m_wdata});
                    end
                    wait_cnt = $urandom_range(0, 3);
                end else wait_cnt--;
            end
        end
    end

    task automatic cfg_xfer(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] r);
        @(negedge clk);
        sel = 1; addr = a; wstrb = s; wdata = d; last_lat = 0;
        do begin @(posedge clk); #1; last_lat++; end while (!ready && last_lat < 8);
        r = rdata;
        @(negedge clk);
        sel = 0; wstrb = 0;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        cfg_xfer(a, 4'hF, d, r);
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [31:0] r);
        cfg_xfer(a, 4'h0, 32'h0, r);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1; break; end
        end
    endtask

    // Reference: ascending word-by-word copy over a snapshot of memory.
    task automatic build_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        ref_mem = mem;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] sa, da, v;
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            v  = ref_mem[sa[11:2]];
            exp_q.push_back('{1'b0, sa, v});
            ref_mem[da[11:2]] = v;
            exp_q.push_back('{1'b1, da, v});
        end
    endtask

    function automatic bit txn_match();
        if (obs_q.size() != exp_q.size()) return 0;
        foreach (exp_q[i])
            if (obs_q[i].w !== exp_q[i].w || obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d)
                return 0;
        return 1;
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        int rdy;
        reset_n = 0; sel = 0; addr = 0; wstrb = 0; wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            cfg_rd(4'(i * 4), r);
            vectors++;
            if (r !== 32'h0 || last_lat !== 1) begin
                miscompares++;
                $display("FAIL reset_reg%0d: rdata=%h latency=%0d, required 0 latency=1", i, r, last_lat);
            end
        end
        vectors++;
        if (done !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: done=%b m_valid=%b, required 0 0", done, m_valid);
        end
        @(negedge clk);
        sel = 1; addr = 4'h0; wstrb = 0; rdy = 0;
        repeat (4) begin @(posedge clk); #1; if (ready) rdy++; end
        @(negedge clk) sel = 0;
        vectors++;
        if (rdy !== 1) begin
            miscompares++;
            $display("FAIL ready_pulse: %0d ready cycles for one held sel, required 1", rdy);
        end
    endtask

    task automatic test_copy_basic();
        logic [31:0] r;
        bit ok;
        mem[32'h100 >> 2] = 32'hA; mem[32'h104 >> 2] = 32'hB; mem[32'h108 >> 2] = 32'hC;
        cfg_wr(4'h0, 32'h100); cfg_wr(4'h4, 32'h200); cfg_wr(4'h8, 32'd3);
        build_copy(32'h100, 32'h200, 3);
        cfg_wr(4'hC, 32'h1);
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_done: done=%b, required 1", done); end
        vectors++;
        if (txn_match() !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_bus: %0d transfers seen, required %0d matching", obs_q.size(), exp_q.size());
        end
        cfg_rd(4'hC, r);
        vectors++;
        if (r !== 32'h2) begin miscompares++; $display("FAIL basic_ctrl: got %h required 2", r); end
        cfg_rd(4'h0, r);
        vectors++;
        if (r !== 32'h100) begin miscompares++; $display("FAIL basic_src_kept: got %h required 100", r); end
    endtask

    task automatic test_random_copy();
        logic [31:0] s, d, r, old, nw, mask, expv;
        logic [3:0] be;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            int n;
            for (int i = 0; i < 1024; i++) mem[i] = $urandom;
            n = $urandom_range(1, 6);
            s = 32'($urandom_range(0, 1000)) << 2;
            d = (k == 1) ? s + 32'h4 : 32'($urandom_range(0, 1000)) << 2;
            if (k == 2) s = 32'hFFFF_FFF8;
            cfg_wr(4'h0, s); cfg_wr(4'h4, d); cfg_wr(4'h8, 32'(n));
            build_copy(s, d, n);
            cfg_wr(4'hC, 32'h1);
            wait_done(ok);
            vectors++;
            if (ok !== 1'b1 || txn_match() !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_copy%0d: done=%b transfers=%0d, required done=1 %0d matching",
                         k, ok, obs_q.size(), exp_q.size());
            end
        end
        old = $urandom; nw = $urandom; be = 4'($urandom);
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        cfg_wr(4'h4, old);
        cfg_xfer(4'h4, be, nw, r);
        cfg_rd(4'h4, r);
        expv = ((old & ~mask) | (nw & mask)) & 32'hFFFF_FFFC;
        vectors++;
        if (r !== expv) begin miscompares++; $display("FAIL dst_strobe: got %h required %h", r, expv); end
        cfg_wr(4'h8, 32'h5);
        cfg_xfer(4'h8, 4'b1110, 32'hFFFF_1234, r);
        cfg_rd(4'h8, r);
        vectors++;
        if (r !== 32'h1205) begin miscompares++; $display("FAIL len_strobe: got %h required 1205", r); end
    endtask

    task automatic test_len_zero();
        logic [31:0] r;
        int vc;
        cfg_wr(4'hC, 32'h2);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL clear_done: done=%b required 0", done); end
        cfg_wr(4'h8, 32'h0);
        vc = valid_cnt;
        cfg_xfer(4'hC, 4'hF, 32'h1, r);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL len0_done: done=%b required 1", done); end
        repeat (10) @(posedge clk);
        vectors++;
        if (valid_cnt !== vc) begin
            miscompares++;
            $display("FAIL len0_nobus: %0d m_valid cycles, required 0", valid_cnt - vc);
        end
    endtask

    task automatic test_busy_lockout();
        logic [31:0] r;
        bit ok;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        cfg_wr(4'h0, 32'h400); cfg_wr(4'h4, 32'h600); cfg_wr(4'h8, 32'd4);
        build_copy(32'h400, 32'h600, 4);
        cfg_wr(4'hC, 32'h1);
        cfg_wr(4'h0, 32'hDEAD_0000);
        cfg_wr(4'hC, 32'h1);
        cfg_rd(4'h0, r);
        vectors++;
        if (r !== 32'h400) begin miscompares++; $display("FAIL lockout_src: got %h required 400", r); end
        cfg_rd(4'hC, r);
        vectors++;
        if (r !== 32'h1) begin miscompares++; $display("FAIL lockout_busy: got %h required 1", r); end
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || txn_match() !== 1'b1) begin
            miscompares++;
            $display("FAIL lockout_bus: done=%b transfers=%0d, required done=1 %0d matching",
                     ok, obs_q.size(), exp_q.size());
        end
        cfg_wr(4'h0, 32'h800); cfg_wr(4'h4, 32'hA00); cfg_wr(4'h8, 32'd2);
        build_copy(32'h800, 32'hA00, 2);
        cfg_wr(4'hC, 32'h3);
        cfg_rd(4'hC, r);
        vectors++;
        if (r !== 32'h1) begin miscompares++; $display("FAIL start_and_clear: got %h required 1", r); end
        cfg_wr(4'hC, 32'h2);
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || txn_match() !== 1'b1) begin
            miscompares++;
            $display("FAIL second_copy: done=%b transfers=%0d, required done=1 %0d matching",
                     ok, obs_q.size(), exp_q.size());
        end
        cfg_wr(4'hC, 32'h2);
        cfg_rd(4'hC, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL done_cleared: got %h required 0", r); end
    endtask

    task automatic test_reset_midtransfer();
        logic [31:0] r;
        bit in_wr;
        int vc;
        hold_wr = 1;
        cfg_wr(4'h0, 32'h100); cfg_wr(4'h4, 32'h300); cfg_wr(4'h8, 32'd2);
        cfg_wr(4'hC, 32'h1);
        in_wr = 0;
        for (int i = 0; i < 100 && !in_wr; i++) begin
            @(posedge clk); #1;
            if (m_valid && m_wstrb == 4'hF) in_wr = 1;
        end
        vectors++;
        if (in_wr !== 1'b1) begin miscompares++; $display("FAIL reach_wr: never saw write, required one"); end
        @(negedge clk) reset_n = 0;
        @(posedge clk); #1;
        vectors++;
        if (m_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: m_valid=%b done=%b, required 0 0", m_valid, done);
        end
        @(negedge clk) reset_n = 1;
        hold_wr = 0;
        vc = valid_cnt;
        repeat (20) @(posedge clk);
        vectors++;
        if (valid_cnt !== vc) begin
            miscompares++;
            $display("FAIL abort_quiet: %0d m_valid cycles, required 0", valid_cnt - vc);
        end
        for (int i = 0; i < 4; i++) begin
            cfg_rd(4'(i * 4), r);
            vectors++;
            if (r !== 32'h0) begin miscompares++; $display("FAIL abort_reg%0d: got %h required 0", i, r); end
        end
    endtask

`ifdef DMA_FILL_EN
    task automatic test_fill();
        logic [31:0] r;
        bit ok;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back('{1'b1, 32'h300, 32'h5A5A_5A5A});
        exp_q.push_back('{1'b1, 32'h304, 32'h5A5A_5A5A});
        cfg_wr(4'h0, 32'h5A5A_5A5A); cfg_wr(4'h4, 32'h300); cfg_wr(4'h8, 32'd2);
        cfg_wr(4'hC, 32'h5);
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || txn_match() !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_bus: done=%b transfers=%0d, required done=1 2 writes", ok, obs_q.size());
        end
        cfg_rd(4'hC, r);
        vectors++;
        if (r !== 32'h6) begin miscompares++; $display("FAIL fill_ctrl: got %h required 6", r); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_copy_basic();
        test_random_copy();
        test_len_zero();
        test_busy_lockout();
        test_reset_midtransfer();
`ifdef DMA_FILL_EN
        test_fill();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Word-granular memory-to-memory copy engine.
- CPU-programmed through a 4-register responder port (sel/wstrb/wdata/rdata/ready, same native handshake as the other peripherals).
- Performs the copy as a bus initiator on a second native-style port (valid/addr/wdata/wstrb/rdata/ready), arbitrated against cpu0 at top level.
- Raises a sticky done flag on completion.

Parameters:
- LEN_WIDTH, 16: width of the word-count register; max transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- sel  input  1  config-port select (decoded valid & address match)
- addr  input  4  config byte address; bits [3:2] select the register
- wstrb  input  4  config write strobes; 0 = read
- wdata  input  32  config write data
- rdata  output  32  config read data
- ready  output  1  config access complete
- m_valid  output  1  initiator request
- m_addr  output  32  initiator word address; bits [1:0] always 0
- m_wdata  output  32  initiator write data
- m_wstrb  output  4  4'hF for a write, 4'h0 for a read
- m_rdata  input  32  initiator read data
- m_ready  input  1  initiator transfer complete
- done  output  1  sticky completion flag; usable as an irq

Behaviour:
- Reset: one clk edge with reset_n=0 does all of the following.
  - SRC, DST, LEN and CTRL are cleared.
  - FSM goes to IDLE.
  - ready, m_valid and done go to 0; m_addr, m_wdata, m_wstrb and rdata go to 0.
  - A reset mid-transfer aborts immediately; no further m_valid is issued.
- Register map (addr[3:2]):
  - 0 SRC [31:0]; bits [1:0] read 0.
  - 1 DST [31:0]; bits [1:0] read 0.
  - 2 LEN [LEN_WIDTH-1:0].
  - 3 CTRL.
    - Write bit0=1: start.
    - Write bit1=1: clear done.
    - Read: bit0=busy, bit1=done.
- Config handshake:
  - ready pulses for exactly one cycle, in the cycle after sel is first sampled high.
  - rdata is valid in that ready cycle.
  - A write takes effect on the same edge that raises ready.
  - A new access needs sel low for at least one cycle between accesses.
  - Byte strobes are honoured per byte for SRC/DST/LEN. CTRL acts on wstrb[0] only.
- Busy lockout:
  - While busy, writes to SRC/DST/LEN and start are ignored but still acknowledged.
  - Clearing done while busy is permitted.
- FSM states: IDLE, RD, WR.
  - IDLE + start:
    - LEN==0: done<=1 and stay in IDLE; no bus traffic.
    - LEN!=0: load the working counters (cur_src, cur_dst, remaining); done<=0; go to RD.
  - RD:
    - m_valid=1, m_addr=cur_src, m_wstrb=0.
    - On m_ready: latch m_rdata, cur_src+=4, go to WR.
  - WR:
    - m_valid=1, m_addr=cur_dst, m_wdata=latched word, m_wstrb=4'hF.
    - On m_ready: cur_dst+=4, remaining-=1.
    - If remaining was 1: done<=1 and go to IDLE; else go to RD.
- Initiator rules:
  - addr/wdata/wstrb are stable while m_valid=1 and m_ready=0.
  - m_valid drops for exactly one cycle after each accepted transfer.
  - Minimum 2 cycles per transfer, so a word copy takes ≥4 cycles.
  - m_ready is ignored while m_valid=0.
- Arithmetic:
  - Address increments wrap modulo 2^32.
  - Programmed SRC/DST registers are not modified by a transfer; reads return the programmed values.
- Simultaneous start and clear-done in one write: start wins, and done reads 0 until completion.
- Overlapping src/dst ranges: copy proceeds word by word in ascending order; no special handling.

Optional Feature:
- Macro DMA_FILL_EN.
- When defined:
  - CTRL bit2 = fill mode (R/W, latched at start).
  - In fill mode the FSM skips RD: it writes the SRC register value as constant data to LEN words starting at DST.
  - Each word takes ≥2 cycles.
- When undefined: CTRL bit2 is read-as-zero, writes to it are ignored, and there is no fill logic.

Test Plan:
- Reset then read all 4 registers -> rdata 0 each, with ready one cycle after sel; done=0, m_valid=0.
- SRC=0x100, DST=0x200, LEN=3 preloaded with 0xA,0xB,0xC, CTRL=1, memory model ready after 0–3 random wait cycles -> bus sequence R100,W200=0xA,R104,W204=0xB,R108,W208=0xC; then done=1, CTRL reads 0x2.
- LEN=0, start -> done=1 on the following cycle; m_valid never asserts.
- During a busy transfer, write SRC=0xDEAD0000 and start -> acknowledged but ignored; the transfer finishes with the original addresses; then write CTRL=2 -> done=0.
- Assert reset_n=0 while in WR with m_ready held low -> next cycle m_valid=0, FSM IDLE, registers 0; no later bus activity.
- DMA_FILL_EN: SRC=0x5A5A5A5A, DST=0x300, LEN=2, CTRL=0x5 -> only writes: W300 and W304 = 0x5A5A5A5A; done=1.
